// File: rtl/uart_frame_pkg.sv
// Shared definitions for the UART frame controller: parser states, error codes, SOF default.
package uart_frame_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_LEN,
    ST_DATA,
    ST_CHK,
    ST_COMMIT
  } state_e;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_LEN  = 2'b01;
  localparam logic [1:0] ERR_CHK  = 2'b10;
  localparam logic [1:0] ERR_TMO  = 2'b11;

  localparam logic [7:0] SOF_DEFAULT = 8'hA5;

endpackage

// File: rtl/frame_payload_buf.sv
// Payload holding buffer: one synchronous write port, one combinational read port.
module frame_payload_buf #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          i_Clk,
  input  logic          i_We,
  input  logic [AW-1:0] i_WAddr,
  input  logic [7:0]    i_WData,
  input  logic [AW-1:0] i_RAddr,
  output logic [7:0]    o_RData
);

  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge i_Clk) begin
    if (i_We) mem_q[i_WAddr] <= i_WData;
  end

  assign o_RData = mem_q[i_RAddr];

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// Parses SOF/ADDR/LEN/PAYLOAD/CHK frames from the UART receiver and commits verified payloads.
// Optional inter-byte timeout enabled by defining UART_FRAME_TIMEOUT_EN.
module uart_rx_frame_ctrl
  import uart_frame_pkg::*;
#(
  parameter int         MAX_LEN      = 16,
  parameter logic [7:0] SOF_BYTE     = SOF_DEFAULT,
  parameter int         TIMEOUT_CLKS = 50000
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_fDone,
  input  logic [7:0] i_Data,
  output logic       o_WrEn,
  output logic [7:0] o_WrAddr,
  output logic [7:0] o_WrData,
  output logic       o_fFrameOk,
  output logic       o_fFrameErr,
  output logic [1:0] o_ErrCode,
  output logic       o_Busy
);

  localparam int         LW        = $clog2(MAX_LEN + 1);
  localparam int         AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  state_e          state_q, state_d;
  logic [7:0]      base_q, base_d;
  logic [7:0]      chk_q, chk_d;
  logic [LW-1:0]   len_q, len_d;
  logic [LW-1:0]   idx_q, idx_d;
  logic            ok_q, ok_d;
  logic            err_q, err_d;
  logic [1:0]      code_q, code_d;
  logic            buf_we;
  logic [7:0]      buf_rdata;
  logic            tmo_hit;

  frame_payload_buf #(.DEPTH(MAX_LEN), .AW(AW)) u_buf (
    .i_Clk   (i_Clk),
    .i_We    (buf_we),
    .i_WAddr (idx_q[AW-1:0]),
    .i_WData (i_Data),
    .i_RAddr (idx_q[AW-1:0]),
    .o_RData (buf_rdata)
  );

`ifdef UART_FRAME_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CLKS + 1);
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          tmo_active;

  // Counts silent clocks while a frame is open; any byte restarts the count.
  always_comb begin
    tmo_active = (state_q == ST_ADDR) || (state_q == ST_LEN) ||
                 (state_q == ST_DATA) || (state_q == ST_CHK);
    tmo_cnt_d  = (tmo_active && !i_fDone) ? tmo_cnt_q + TW'(1) : '0;
    tmo_hit    = tmo_active && !i_fDone && (tmo_cnt_q == TW'(TIMEOUT_CLKS - 1));
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) tmo_cnt_q <= '0;
    else       tmo_cnt_q <= tmo_cnt_d;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    chk_d   = chk_q;
    len_d   = len_q;
    idx_d   = idx_q;
    ok_d    = 1'b0;
    err_d   = 1'b0;
    code_d  = ERR_NONE;
    buf_we  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_fDone && (i_Data == SOF_BYTE)) state_d = ST_ADDR;
      end
      ST_ADDR: begin
        if (i_fDone) begin
          base_d  = i_Data;
          chk_d   = i_Data;
          state_d = ST_LEN;
        end
      end
      ST_LEN: begin
        if (i_fDone) begin
          if (i_Data > MAX_LEN_B) begin
            err_d   = 1'b1;
            code_d  = ERR_LEN;
            state_d = ST_IDLE;
          end else begin
            chk_d   = chk_q ^ i_Data;
            len_d   = i_Data[LW-1:0];
            idx_d   = '0;
            state_d = (i_Data == 8'h00) ? ST_CHK : ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (i_fDone) begin
          buf_we = 1'b1;
          chk_d  = chk_q ^ i_Data;
          if ((idx_q + LW'(1)) == len_q) begin
            idx_d   = '0;
            state_d = ST_CHK;
          end else begin
            idx_d = idx_q + LW'(1);
          end
        end
      end
      ST_CHK: begin
        if (i_fDone) begin
          if (i_Data != chk_q) begin
            err_d   = 1'b1;
            code_d  = ERR_CHK;
            state_d = ST_IDLE;
          end else if (len_q == '0) begin
            ok_d    = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_COMMIT;
          end
        end
      end
      ST_COMMIT: begin
        // Bytes arriving here are dropped; line spacing makes that impossible in practice.
        if ((idx_q + LW'(1)) == len_q) begin
          idx_d   = '0;
          ok_d    = 1'b1;
          state_d = ST_IDLE;
        end else begin
          idx_d = idx_q + LW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (tmo_hit) begin
      err_d   = 1'b1;
      code_d  = ERR_TMO;
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= ERR_NONE;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end

  // Frame data registers carry no reset; they are always reloaded before use.
  always_ff @(posedge i_Clk) begin
    base_q <= base_d;
    chk_q  <= chk_d;
    len_q  <= len_d;
  end

  assign o_WrEn      = (state_q == ST_COMMIT);
  assign o_WrAddr    = o_WrEn ? (base_q + 8'(idx_q)) : 8'h00;
  assign o_WrData    = o_WrEn ? buf_rdata : 8'h00;
  assign o_fFrameOk  = ok_q;
  assign o_fFrameErr = err_q;
  assign o_ErrCode   = code_q;
  assign o_Busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Scoreboard bench for uart_rx_frame_ctrl: expected writes/pulses queued at stimulus time.
module tb_uart_rx_frame_ctrl;

  typedef logic [7:0] bq_t[$];

  logic       clk;
  logic       rst;
  logic       i_fDone;
  logic [7:0] i_Data;
  logic       o_WrEn;
  logic [7:0] o_WrAddr;
  logic [7:0] o_WrData;
  logic       o_fFrameOk;
  logic       o_fFrameErr;
  logic [1:0] o_ErrCode;
  logic       o_Busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_done = 0;
  int last_wr   = 0;
  int wr_n      = 0;
  logic [17:0] sb[$];
  logic [17:0] got;
  logic [17:0] exp_ev;
  bq_t tmp;

  uart_rx_frame_ctrl dut (
    .i_Clk       (clk),
    .i_Rst       (rst),
    .i_fDone     (i_fDone),
    .i_Data      (i_Data),
    .o_WrEn      (o_WrEn),
    .o_WrAddr    (o_WrAddr),
    .o_WrData    (o_WrData),
    .o_fFrameOk  (o_fFrameOk),
    .o_fFrameErr (o_fFrameErr),
    .o_ErrCode   (o_ErrCode),
    .o_Busy      (o_Busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic push_wr(input logic [7:0] a, input logic [7:0] d);
    sb.push_back({2'd0, a, d});
  endtask

  task automatic push_ok();
    sb.push_back({2'd1, 16'h0000});
  endtask

  task automatic push_err(input logic [1:0] code);
    sb.push_back({2'd2, 14'h0000, code});
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    i_fDone = 1'b1;
    i_Data  = b;
    @(posedge clk); #1;
    i_fDone = 1'b0;
    i_Data  = 8'($urandom);
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic send_seq(input bq_t s);
    foreach (s[i]) send_byte(s[i]);
  endtask

  task automatic drain(input string tag);
    repeat (40) @(posedge clk);
    #1;
    check(tag, sb.size(), 0);
    sb.delete();
    wr_n = 0;
  endtask

  // Builds a frame of random payload, pushes the expected writes, and sends it.
  task automatic model_frame(input logic [7:0] addr, input int len);
    logic [7:0] c;
    logic [7:0] p;
    bq_t s;
    c = addr ^ 8'(len);
    s = {8'hA5, addr, 8'(len)};
    for (int k = 0; k < len; k++) begin
      p = 8'($urandom);
      s.push_back(p);
      c = c ^ p;
      push_wr(addr + 8'(k), p);
    end
    s.push_back(c);
    push_ok();
    send_seq(s);
  endtask

  // Output monitor: every write or pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (i_fDone) last_done = cyc;
    if (!rst && (o_WrEn || o_fFrameOk || o_fFrameErr)) begin
      if (o_WrEn)          got = {2'd0, o_WrAddr, o_WrData};
      else if (o_fFrameOk) got = {2'd1, 16'h0000};
      else                 got = {2'd2, 14'h0000, o_ErrCode};
      if (sb.size() == 0) begin
        check("unexpected_event", 32'(got), 32'h3FFFF);
      end else begin
        exp_ev = sb.pop_front();
        check("event", 32'(got), 32'(exp_ev));
      end
      if (o_WrEn) begin
        if (wr_n == 0) check("wr_latency", cyc - last_done, 1);
        else           check("wr_spacing", cyc - last_wr, 1);
        last_wr = cyc;
        wr_n++;
      end else begin
        check("ok_err_exclusive", {30'd0, o_fFrameOk, o_fFrameErr} == 32'd3, 0);
        if (o_fFrameOk && wr_n > 0)                 check("ok_after_last_wr", cyc - last_wr, 1);
        else if (!(o_fFrameErr && o_ErrCode == 2'b11)) check("pulse_latency", cyc - last_done, 1);
        wr_n = 0;
      end
      if (!o_fFrameErr) check("code_zero", o_ErrCode, 0);
    end
  end

  initial begin
    rst     = 1'b1;
    i_fDone = 1'b0;
    i_Data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_wren", o_WrEn, 0);
    check("rst_addr", o_WrAddr, 0);
    check("rst_data", o_WrData, 0);
    check("rst_ok", o_fFrameOk, 0);
    check("rst_err", o_fFrameErr, 0);
    check("rst_code", o_ErrCode, 0);
    check("rst_busy", o_Busy, 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Basic two-byte frame
    push_wr(8'h10, 8'h11); push_wr(8'h11, 8'h22); push_ok();
    tmp = {8'hA5, 8'h10, 8'h02, 8'h11, 8'h22, 8'h21};
    send_seq(tmp);
    drain("t1_drain");
    check("t1_idle", o_Busy, 0);

    // Bad checksum
    push_err(2'b10);
    tmp = {8'hA5, 8'h10, 8'h02, 8'h11, 8'h22, 8'h20};
    send_seq(tmp);
    drain("t2_drain");

    // Oversized LEN, then a good frame
    push_err(2'b01);
    tmp = {8'hA5, 8'h05, 8'h11};
    send_seq(tmp);
    drain("t3_drain");
    check("t3_idle", o_Busy, 0);
    push_wr(8'h40, 8'h5A); push_ok();
    tmp = {8'hA5, 8'h40, 8'h01, 8'h5A, 8'h1B};
    send_seq(tmp);
    drain("t3b_drain");

    // Address wrap
    push_wr(8'hFF, 8'h01); push_wr(8'h00, 8'h02); push_ok();
    tmp = {8'hA5, 8'hFF, 8'h02, 8'h01, 8'h02, 8'hFE};
    send_seq(tmp);
    drain("t4_drain");

    // Empty payload with leading noise
    push_ok();
    tmp = {8'h00, 8'h55, 8'hA5, 8'h30, 8'h00, 8'h30};
    send_seq(tmp);
    drain("t5_drain");

    // Maximum length, including a wrap and an embedded SOF value
    model_frame(8'h20, 16);
    drain("max_len_drain");
    model_frame(8'hF8, 16);
    drain("max_wrap_drain");
    push_wr(8'h60, 8'hA5); push_ok();
    tmp = {8'hA5, 8'h60, 8'h01, 8'hA5, 8'hC4};
    send_seq(tmp);
    drain("sof_as_data_drain");

    // Reset mid-DATA abandons the frame silently
    send_byte(8'hA5);
    check("busy_after_sof", o_Busy, 1);
    tmp = {8'h10, 8'h02, 8'h11};
    send_seq(tmp);
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_busy", o_Busy, 0);
    check("mid_rst_wren", o_WrEn, 0);
    check("mid_rst_pulses", {o_fFrameOk, o_fFrameErr, o_ErrCode}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    drain("mid_rst_quiet");
    push_wr(8'h10, 8'h11); push_wr(8'h11, 8'h22); push_ok();
    tmp = {8'hA5, 8'h10, 8'h02, 8'h11, 8'h22, 8'h21};
    send_seq(tmp);
    drain("after_rst_drain");

`ifdef UART_FRAME_TIMEOUT_EN
    push_err(2'b11);
    tmp = {8'hA5, 8'h10};
    send_seq(tmp);
    repeat (50100) @(posedge clk);
    #1;
    check("tmo_drain", sb.size(), 0);
    check("tmo_idle", o_Busy, 0);
    sb.delete();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
